// File: rtl/cpu_writeback.sv
// Writeback stage: buffers execute results in a small in-order FIFO, arbitrates them
// against returning loads (loads win), and tracks outstanding loads for hazard checks.
module cpu_writeback #(
  parameter int unsigned EX_FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [3:0]  ex_index_i,
  input  logic [31:0] ex_value_i,
  input  logic        ld_issue_i,
  input  logic [3:0]  ld_issue_index_i,
  input  logic        ld_valid_i,
  input  logic [3:0]  ld_index_i,
  input  logic [31:0] ld_value_i,
  input  logic [3:0]  rd_index1_i,
  input  logic [3:0]  rd_index2_i,
  output logic        busy1_o,
  output logic        busy2_o,
  output logic        write_enable_o,
  output logic [3:0]  reg_write_index_o,
  output logic [31:0] value_o,
  output logic [15:0] pending_o
);

  localparam int unsigned PtrW = (EX_FIFO_DEPTH > 1) ? $clog2(EX_FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(EX_FIFO_DEPTH);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [3:0]      mem_idx_q [EX_FIFO_DEPTH];
  logic [31:0]     mem_val_q [EX_FIFO_DEPTH];

  logic        we_q, we_d;
  logic [3:0]  wb_idx_q, wb_idx_d;
  logic [31:0] wb_val_q, wb_val_d;
  logic [15:0] pending_q, pending_d;

  logic push, pop, fifo_nonempty;

  // Gating with rst_i keeps ready low for the whole reset window, not just after the edge.
  assign ex_ready_o    = rst_i && (count_q < DepthCnt);
  assign fifo_nonempty = (count_q != '0);
  assign push          = ex_valid_i && ex_ready_o;
  assign pop           = !ld_valid_i && fifo_nonempty;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    we_d     = ld_valid_i || fifo_nonempty;
    wb_idx_d = wb_idx_q;
    wb_val_d = wb_val_q;
    if (ld_valid_i) begin
      wb_idx_d = ld_index_i;
      wb_val_d = ld_value_i;
    end else if (fifo_nonempty) begin
      wb_idx_d = mem_idx_q[rd_ptr_q];
      wb_val_d = mem_val_q[rd_ptr_q];
    end
  end

  // Clear first so a same-cycle issue to the same register leaves the bit set.
  always_comb begin
    pending_d = pending_q;
    if (ld_valid_i) pending_d[ld_index_i] = 1'b0;
    if (ld_issue_i) pending_d[ld_issue_index_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      we_q      <= 1'b0;
      wb_idx_q  <= '0;
      wb_val_q  <= '0;
      pending_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      we_q      <= we_d;
      wb_idx_q  <= wb_idx_d;
      wb_val_q  <= wb_val_d;
      pending_q <= pending_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_idx_q[wr_ptr_q] <= ex_index_i;
      mem_val_q[wr_ptr_q] <= ex_value_i;
    end
  end

  always_comb begin
    logic [PtrW-1:0] slot;
    busy1_o = pending_q[rd_index1_i] || (we_q && (wb_idx_q == rd_index1_i));
    busy2_o = pending_q[rd_index2_i] || (we_q && (wb_idx_q == rd_index2_i));
    for (int unsigned k = 0; k < EX_FIFO_DEPTH; k++) begin
      slot = rd_ptr_q + PtrW'(k);
      if (CntW'(k) < count_q) begin
        if (mem_idx_q[slot] == rd_index1_i) busy1_o = 1'b1;
        if (mem_idx_q[slot] == rd_index2_i) busy2_o = 1'b1;
      end
    end
  end

  assign write_enable_o    = we_q;
  assign reg_write_index_o = wb_idx_q;
  assign value_o           = wb_val_q;
  assign pending_o         = pending_q;

endmodule

// File: tb/tb_cpu_writeback.sv
// Directed bench for cpu_writeback: execute/load arbitration, FIFO backpressure,
// load scoreboard and reset behaviour, with hand-computed expectations.
module tb_cpu_writeback;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [3:0]  ex_index_i;
  logic [31:0] ex_value_i;
  logic        ld_issue_i;
  logic [3:0]  ld_issue_index_i;
  logic        ld_valid_i;
  logic [3:0]  ld_index_i;
  logic [31:0] ld_value_i;
  logic [3:0]  rd_index1_i;
  logic [3:0]  rd_index2_i;
  logic        busy1_o;
  logic        busy2_o;
  logic        write_enable_o;
  logic [3:0]  reg_write_index_o;
  logic [31:0] value_o;
  logic [15:0] pending_o;

  int unsigned pass_cnt = 0;
  int unsigned fail_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 clk_i = ~clk_i;

  cpu_writeback #(.EX_FIFO_DEPTH(2)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .ex_valid_i        (ex_valid_i),
    .ex_ready_o        (ex_ready_o),
    .ex_index_i        (ex_index_i),
    .ex_value_i        (ex_value_i),
    .ld_issue_i        (ld_issue_i),
    .ld_issue_index_i  (ld_issue_index_i),
    .ld_valid_i        (ld_valid_i),
    .ld_index_i        (ld_index_i),
    .ld_value_i        (ld_value_i),
    .rd_index1_i       (rd_index1_i),
    .rd_index2_i       (rd_index2_i),
    .busy1_o           (busy1_o),
    .busy2_o           (busy2_o),
    .write_enable_o    (write_enable_o),
    .reg_write_index_o (reg_write_index_o),
    .value_o           (value_o),
    .pending_o         (pending_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wb(input string tag, input logic we, input logic [3:0] idx,
                    input logic [31:0] val);
    chk({tag, ".we"}, 32'(write_enable_o), 32'(we));
    chk({tag, ".idx"}, 32'(reg_write_index_o), 32'(idx));
    chk({tag, ".val"}, value_o, val);
  endtask

  initial begin
    rst_i = 1'b0;
    ex_valid_i = 1'b0; ex_index_i = '0; ex_value_i = '0;
    ld_issue_i = 1'b0; ld_issue_index_i = '0;
    ld_valid_i = 1'b0; ld_index_i = '0; ld_value_i = '0;
    rd_index1_i = '0; rd_index2_i = '0;
    #1;
    wb("rst", 1'b0, 4'd0, 32'h0);
    chk("rst.pending", 32'(pending_o), 32'h0);
    chk("rst.ready", 32'(ex_ready_o), 32'h0);
    chk("rst.busy1", 32'(busy1_o), 32'h0);
    tick(); tick();
    rst_i = 1'b1;
    #1;
    chk("post_rst.ready", 32'(ex_ready_o), 32'h1);

    // Single execute result r3
    ex_valid_i = 1'b1; ex_index_i = 4'd3; ex_value_i = 32'h0000_00AA;
    tick();
    ex_valid_i = 1'b0;
    chk("ex1.we_lat", 32'(write_enable_o), 32'h0);
    rd_index1_i = 4'd3;
    #1;
    chk("ex1.busy_fifo", 32'(busy1_o), 32'h1);
    tick();
    wb("ex1.wr", 1'b1, 4'd3, 32'hAA);
    chk("ex1.busy_wb", 32'(busy1_o), 32'h1);
    tick();
    wb("ex1.hold", 1'b0, 4'd3, 32'hAA);
    chk("ex1.busy_done", 32'(busy1_o), 32'h0);

    // Load r5 beats queued r2
    ex_valid_i = 1'b1; ex_index_i = 4'd2; ex_value_i = 32'h0000_0022;
    ld_valid_i = 1'b1; ld_index_i = 4'd5; ld_value_i = 32'h1234_5678;
    tick();
    ex_valid_i = 1'b0; ld_valid_i = 1'b0;
    wb("ldpri.ld", 1'b1, 4'd5, 32'h1234_5678);
    chk("ldpri.pending", 32'(pending_o), 32'h0);
    tick();
    wb("ldpri.ex", 1'b1, 4'd2, 32'h22);
    tick();
    chk("ldpri.idle", 32'(write_enable_o), 32'h0);

    // Loads held 4 cycles while r1,r2,r4 offered; FIFO (depth 2) fills
    rd_index1_i = 4'd2; rd_index2_i = 4'd4;
    ld_valid_i = 1'b1; ld_index_i = 4'd10;
    ex_valid_i = 1'b1;
    ld_value_i = 32'h100; ex_index_i = 4'd1; ex_value_i = 32'h11;
    #1;
    chk("bp.ready0", 32'(ex_ready_o), 32'h1);
    tick();
    wb("bp.ld0", 1'b1, 4'd10, 32'h100);
    ld_value_i = 32'h101; ex_index_i = 4'd2; ex_value_i = 32'h12;
    #1;
    chk("bp.ready1", 32'(ex_ready_o), 32'h1);
    tick();
    wb("bp.ld1", 1'b1, 4'd10, 32'h101);
    ld_value_i = 32'h102; ex_index_i = 4'd4; ex_value_i = 32'h14;
    #1;
    chk("bp.ready2", 32'(ex_ready_o), 32'h0);
    chk("bp.busy_r2", 32'(busy1_o), 32'h1);
    chk("bp.busy_r4", 32'(busy2_o), 32'h0);
    tick();
    wb("bp.ld2", 1'b1, 4'd10, 32'h102);
    ld_value_i = 32'h103;
    #1;
    chk("bp.ready3", 32'(ex_ready_o), 32'h0);
    tick();
    wb("bp.ld3", 1'b1, 4'd10, 32'h103);
    ld_valid_i = 1'b0; ex_valid_i = 1'b0;
    tick();
    wb("bp.r1", 1'b1, 4'd1, 32'h11);
    tick();
    wb("bp.r2", 1'b1, 4'd2, 32'h12);
    tick();
    wb("bp.drained", 1'b0, 4'd2, 32'h12);
    chk("bp.ready_after", 32'(ex_ready_o), 32'h1);

    // Scoreboard on r7
    rd_index1_i = 4'd7; rd_index2_i = 4'd0;
    ld_issue_i = 1'b1; ld_issue_index_i = 4'd7;
    tick();
    ld_issue_i = 1'b0;
    chk("sb7.pending", 32'(pending_o), 32'h0080);
    chk("sb7.busy", 32'(busy1_o), 32'h1);
    ld_valid_i = 1'b1; ld_index_i = 4'd7; ld_value_i = 32'h77;
    tick();
    ld_valid_i = 1'b0;
    chk("sb7.cleared", 32'(pending_o), 32'h0);
    wb("sb7.wr", 1'b1, 4'd7, 32'h77);
    chk("sb7.busy_wb", 32'(busy1_o), 32'h1);
    tick();
    chk("sb7.busy_done", 32'(busy1_o), 32'h0);

    // Issue and return on r9 in the same cycle
    ld_issue_i = 1'b1; ld_issue_index_i = 4'd9;
    ld_valid_i = 1'b1; ld_index_i = 4'd9; ld_value_i = 32'h99;
    tick();
    ld_issue_i = 1'b0; ld_valid_i = 1'b0;
    chk("sb9.pending", 32'(pending_o), 32'h0200);
    wb("sb9.wr", 1'b1, 4'd9, 32'h99);
    tick();
    chk("sb9.once", 32'(write_enable_o), 32'h0);
    chk("sb9.pending_kept", 32'(pending_o), 32'h0200);

    // Fill FIFO and scoreboard, then reset mid-operation
    rd_index1_i = 4'd14; rd_index2_i = 4'd3;
    ex_valid_i = 1'b1; ex_index_i = 4'd14; ex_value_i = 32'hEE;
    ld_issue_i = 1'b1; ld_valid_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ld_issue_index_i = 4'(i); ld_index_i = 4'(i); ld_value_i = 32'(i);
      tick();
    end
    chk("full.pending", 32'(pending_o), 32'hFFFF);
    chk("full.ready", 32'(ex_ready_o), 32'h0);
    rst_i = 1'b0;
    ex_valid_i = 1'b0; ld_issue_i = 1'b0; ld_valid_i = 1'b0;
    #1;
    wb("arst", 1'b0, 4'd0, 32'h0);
    chk("arst.pending", 32'(pending_o), 32'h0);
    chk("arst.ready", 32'(ex_ready_o), 32'h0);
    chk("arst.busy1", 32'(busy1_o), 32'h0);
    chk("arst.busy2", 32'(busy2_o), 32'h0);
    tick(); tick();
    rst_i = 1'b1;
    #1;
    chk("rel.ready", 32'(ex_ready_o), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      wb("rel.nowr", 1'b0, 4'd0, 32'h0);
    end
    chk("rel.busy1", 32'(busy1_o), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
